piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer with valid/ready load handshake, per-word bit length, per-word shift direction and an output stall input. It takes a right-aligned word from an upstream producer and emits it one bit per enabled clock, with valid and last flags for the serial sink. It replaces fixed 4-bit, right-shift-only PISO instances in serial transmit paths, including framers and SPI/UART-style TX front ends.

---
 rtl/piso_serializer_if.sv | 29 ++
 rtl/piso_serializer.sv | 80 ++++++++
 tb/tb_piso_serializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load/serial-out bus for piso_serializer: upstream word handshake plus the
// serial sink side (bit, valid, last, stall, word-done pulse).
interface piso_serializer_if #(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
);
    logic [N-1:0]  data_in;
    logic [LW-1:0] len_in;
    logic          msb_first;
    logic          in_valid;
    logic          in_ready;
    logic          out_en;
    logic          sout;
    logic          sout_valid;
    logic          sout_last;
    logic          word_done;

    // Producer/sink side: drives words in and the stall, observes the stream.
    modport master (
        output data_in, len_in, msb_first, in_valid, out_en,
        input  in_ready, sout, sout_valid, sout_last, word_done
    );

    // Serializer side.
    modport slave (
        input  data_in, len_in, msb_first, in_valid, out_en,
        output in_ready, sout, sout_valid, sout_last, word_done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. Accepts a right-aligned word of 1..N
// bits, emits it one bit per out_en cycle in either direction, and reloads
// on the last bit's edge so back-to-back words stream without a gap.
// The remaining-bit counter doubles as the state: cnt == 0 is idle,
// cnt >= 1 is shifting.
module piso_serializer #(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    logic [N-1:0]  sr_q, sr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          word_done_q, word_done_d;

    logic [LW-1:0] eff_len;
    logic          live;
    logic          last;
    logic          ready;
    logic          accept;
    logic          consume;

    // Status derived only from state and out_en, so in_ready never depends on in_valid.
    always_comb begin
        live  = (cnt_q != '0);
        last  = (cnt_q == LW'(1));
        ready = !live || (bus.out_en && last);
    end

    // Length 0 and anything larger than the word both mean a full word.
    always_comb begin
        eff_len = bus.len_in;
        if (bus.len_in == '0 || bus.len_in > LW'(N))
            eff_len = LW'(N);
    end

    // Next-state: a load takes priority over a shift, which covers the
    // last-bit-plus-new-word edge; a stalled sink leaves everything held.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        accept      = bus.in_valid && ready;
        consume     = live && bus.out_en;
        word_done_d = consume && last;
        if (accept) begin
            // MSB-first words are left-justified so bit L-1 sits at sr[N-1].
            sr_d  = bus.msb_first ? (bus.data_in << (LW'(N) - eff_len)) : bus.data_in;
            cnt_d = eff_len;
            dir_d = bus.msb_first;
        end else if (consume) begin
            sr_d  = dir_q ? (sr_q << 1) : (sr_q >> 1);
            cnt_d = cnt_q - LW'(1);
        end
    end

    // State registers; reset wins over any load or shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.sout_valid = live;
    assign bus.sout_last  = last;
    assign bus.sout       = live & (dir_q ? sr_q[N-1] : sr_q[0]);
    assign bus.word_done  = word_done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: expected bits are queued when a word
// is accepted and compared against sout as the sink consumes them.
module tb_piso_serializer;
    localparam int N  = 8;
    localparam int LW = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_serializer_if #(.N(N), .LW(LW)) bus();
    piso_serializer #(.N(N), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t        q[$];
    int          errs   = 0;
    int          checks = 0;
    logic        wd_exp = 1'b0;
    logic        mon_en = 1'b0;
    logic        acc    = 1'b0;
    logic [31:0] stream = '0;
    int          nbits  = 0;
    int          vrun   = 0;
    int          last_run = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [LW-1:0] l);
        return (l == 0 || l > N) ? N : int'(l);
    endfunction

    // Monitor + scoreboard, sampled on the falling edge.
    exp_t e;
    logic rdy_exp;
    int   wl;
    int   kk;
    always @(negedge clk) begin
        if (mon_en) begin
            rdy_exp = (q.size() == 0) || (bus.out_en && q[0].last);
            chk("word_done", bus.word_done, wd_exp);
            chk("sout_valid", bus.sout_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, rdy_exp);
            if (q.size() != 0) begin
                chk("sout", bus.sout, q[0].b);
                chk("sout_last", bus.sout_last, q[0].last);
            end else begin
                chk("sout_idle", bus.sout, 0);
            end
            if (bus.sout_valid) vrun++;
            else begin
                if (vrun != 0) last_run = vrun;
                vrun = 0;
            end
            wd_exp = 1'b0;
            if (rst) begin
                q.delete();
            end else begin
                if (q.size() != 0 && bus.out_en) begin
                    e      = q.pop_front();
                    wd_exp = e.last;
                    stream = {stream[30:0], bus.sout};
                    nbits++;
                end
                if (bus.in_valid && rdy_exp) begin
                    wl = eff(bus.len_in);
                    for (int i = 0; i < wl; i++) begin
                        kk = bus.msb_first ? (wl - 1 - i) : i;
                        q.push_back(exp_t'{b: bus.data_in[kk], last: (i == wl - 1)});
                    end
                    acc = 1'b1;
                end
            end
        end
    end

    // Present a word and hold it until the scoreboard sees it accepted.
    task automatic send(input logic [7:0] d, input logic [LW-1:0] l, input logic m);
        bus.data_in   = d;
        bus.len_in    = l;
        bus.msb_first = m;
        bus.in_valid  = 1'b1;
        acc           = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) @(posedge clk);
        #1;
        if (!acc) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (q.size() != 0 || bus.sout_valid); k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic clr();
        stream = '0;
        nbits  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_en    = 1'b1;
        bus.data_in   = '0;
        bus.len_in    = '0;
        bus.msb_first = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sout", bus.sout, 0);
        chk("rst_sout_valid", bus.sout_valid, 0);
        chk("rst_sout_last", bus.sout_last, 0);
        chk("rst_word_done", bus.word_done, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // full word, LSB first, len 0 means 8
        clr(); send(8'hB4, 0, 1'b0); drain();
        chk("t1_stream", stream, 32'h2D);
        chk("t1_nbits", nbits, 8);

        // same word, MSB first
        clr(); send(8'hB4, 0, 1'b1); drain();
        chk("t2_stream", stream, 32'hB4);

        // short word MSB first: only data_in[2:0]
        clr(); send(8'hFD, 3, 1'b1); drain();
        chk("t3_stream", stream, 32'h5);
        chk("t3_nbits", nbits, 3);

        // back-to-back words, no gap
        clr(); send(8'h0F, 4, 1'b0); send(8'h05, 3, 1'b1); drain();
        chk("t4_stream", stream, 32'h7D);
        chk("t4_run", last_run, 7);

        // length above N means N
        clr(); send(8'h5A, 15, 1'b0); drain();
        chk("t5_stream", stream, 32'h5A);

        // one-bit word with a stall on its only bit
        clr(); send(8'h01, 1, 1'b1);
        bus.out_en = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready_stalled", bus.in_ready, 0);
        bus.out_en = 1'b1;
        drain();
        chk("t6_stream", stream, 32'h1);
        chk("t6_nbits", nbits, 1);

        // three-cycle stall on bit 2
        clr(); send(8'hA5, 8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.out_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_stall_sout", bus.sout, 1);
        chk("t7_stall_ready", bus.in_ready, 0);
        bus.out_en = 1'b1;
        drain();
        chk("t7_stream", stream, 32'hA5);
        chk("t7_nbits", nbits, 8);

        // reset mid-word with a word offered on the reset edge
        clr(); send(8'h3C, 8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.data_in   = 8'hFF;
        bus.len_in    = 8;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("t8_sout_valid", bus.sout_valid, 0);
        chk("t8_sout", bus.sout, 0);
        chk("t8_in_ready", bus.in_ready, 1);
        chk("t8_word_done", bus.word_done, 0);
        @(posedge clk); #1;
        chk("t8_word_done2", bus.word_done, 0);
        clr(); send(8'h96, 8, 1'b1); drain();
        chk("t8_stream", stream, 32'h96);
        chk("t8_nbits", nbits, 8);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
